// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and default widths for the two-port memory arbiter.
package mem_arbiter_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mem_arbiter_pick.sv
// mem_arbiter_pick: combinational two-way winner select.
// Build option MEM_ARB_ROUND_ROBIN_EN: when defined, contention goes to the port
// that did not win last time; otherwise port 0 always wins contention.
module mem_arbiter_pick (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic valid,
  output logic winner
);

  // Winner is only meaningful while valid; a lone requester always wins.
  always_comb begin
    valid = req0 | req1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    winner = (req0 && req1) ? ~last : ~req0;
`else
    winner = ~req0;
`endif
  end

`ifndef MEM_ARB_ROUND_ROBIN_EN
  // Fixed priority has no history; keep the port so both builds share one interface.
  logic unused_last;
  assign unused_last = last;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between two req/ack requesters.
// Build option MEM_ARB_ROUND_ROBIN_EN selects round-robin contention handling
// (adds a last-grant register); the default build uses fixed priority to port 0.
//
// state | meaning
// IDLE  | no access in flight; pick a winner when any request is high
// MEM   | mem_* held stable, waiting for mem_ack
// RESP  | winner's ack is high for this single cycle
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_wr,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_wr,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              grant
);

  state_t state;
  logic   pick_valid;
  logic   pick_winner;
  logic   last_grant;

`ifndef MEM_ARB_ROUND_ROBIN_EN
  assign last_grant = 1'b1;
`endif

  mem_arbiter_pick u_pick (
    .req0   (p0_req),
    .req1   (p1_req),
    .last   (last_grant),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  // Arbitration FSM; every output is a register, so no input reaches an output combinationally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      p0_ack    <= 1'b0;
      p1_ack    <= 1'b0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
      grant     <= 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_grant <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state   <= MEM;
            mem_req <= 1'b1;
            grant   <= pick_winner;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant <= pick_winner;
`endif
            if (pick_winner) begin
              mem_wr    <= p1_wr;
              mem_addr  <= p1_addr;
              mem_wdata <= p1_wdata;
            end else begin
              mem_wr    <= p0_wr;
              mem_addr  <= p0_addr;
              mem_wdata <= p0_wdata;
            end
          end
        end
        MEM: begin
          if (mem_ack) begin
            state   <= RESP;
            mem_req <= 1'b0;
            // Only the granted port's ack/rdata move; writes leave rdata alone.
            if (grant) begin
              p1_ack <= 1'b1;
              if (!mem_wr) p1_rdata <= mem_rdata;
            end else begin
              p0_ack <= 1'b1;
              if (!mem_wr) p0_rdata <= mem_rdata;
            end
          end
        end
        RESP: begin
          state  <= IDLE;
          p0_ack <= 1'b0;
          p1_ack <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
